// File: rtl/mysystem_led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : mysystem_led_fader
//  Brief    : Per-LED brightness fader with PWM output and bypass mode.
//  Revision : 1.0  initial release
// ============================================================================
module mysystem_led_fader #(
    parameter int CLK_DIV   = 50000,
    parameter int FADE_STEP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] pattern_in,
    output logic [7:0] led_out,
    output logic       busy
);

    localparam int             c_NUM_LEDS = 8;
    localparam int             c_PRESC_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);
    localparam logic [7:0]     c_STEP     = 8'(FADE_STEP);

    localparam logic [0:0]     c_IDLE     = 1'b0;
    localparam logic [0:0]     c_FADING   = 1'b1;

    logic [7:0]           r_pattern_q;
    logic [7:0]           r_level [c_NUM_LEDS];
    logic [c_PRESC_W-1:0] r_presc;
    logic [7:0]           r_pwm;
    logic [0:0]           r_state;
    logic                 r_busy;
    logic [7:0]           r_led;

    logic                 w_tick;
    logic [7:0]           w_level_next [c_NUM_LEDS];
    logic [7:0]           w_match;
    logic [7:0]           w_lit;
    logic                 w_any_diff;
    logic [0:0]           w_state_next;
    logic                 w_busy_next;

    assign w_tick = (r_presc == c_PRESC_MAX);

    // Per-LED saturating step toward the target (255 when lit, 0 when dark)
    generate
        for (genvar gi = 0; gi < c_NUM_LEDS; gi++) begin : g_led
            logic [8:0] w_up;
            logic [7:0] w_dn;
            assign w_up             = {1'b0, r_level[gi]} + {1'b0, c_STEP};
            assign w_dn             = (r_level[gi] < c_STEP) ? 8'h00 : (r_level[gi] - c_STEP);
            assign w_level_next[gi] = r_pattern_q[gi] ? (w_up[8] ? 8'hFF : w_up[7:0]) : w_dn;
            assign w_match[gi]      = (r_level[gi] == (r_pattern_q[gi] ? 8'hFF : 8'h00));
            assign w_lit[gi]        = (r_level[gi] == 8'hFF) || (r_pwm < r_level[gi]);
        end
    endgenerate

    assign w_any_diff = ~&w_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern_q <= '0;
            r_presc     <= '0;
            r_pwm       <= '0;
            r_led       <= '0;
        end else begin
            r_pattern_q <= pattern_in;
            r_presc     <= w_tick ? '0 : (r_presc + 1'b1);
            r_pwm       <= r_pwm + 8'd1;
            r_led       <= enable ? w_lit : r_pattern_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_LEDS; i++) r_level[i] <= '0;
        end else if (w_tick && enable) begin
            for (int i = 0; i < c_NUM_LEDS; i++) r_level[i] <= w_level_next[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
        end
    end

    // Dropping enable parks the FSM in IDLE; levels are simply held
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:   if (w_any_diff)  w_state_next = c_FADING;
                c_FADING: if (!w_any_diff) w_state_next = c_IDLE;
                default:  w_state_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_next = (w_state_next == c_FADING);
    end

    assign led_out = r_led;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mysystem_led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mysystem_led_fader
//  Brief    : Directed plus randomized bench for mysystem_led_fader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mysystem_led_fader;

    localparam int CLK_DIV   = 4;
    localparam int FADE_STEP = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] pattern_in;
    logic [7:0] led_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mysystem_led_fader #(
        .CLK_DIV   (CLK_DIV),
        .FADE_STEP (FADE_STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pattern_in (pattern_in),
        .led_out    (led_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural reference: brightness as plain integers clamped to 0..255
    int         m_level [8];
    logic [7:0] m_pq;
    logic [7:0] m_led;
    logic       m_busy;
    int         m_presc;
    int         m_pwm;

    always @(posedge clk or posedge reset) begin : ref_model
        int         nl [8];
        int         tgt;
        logic [7:0] nled;
        logic       diff;
        logic       tick;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_level[i] <= 0;
            m_pq    <= 8'h00;
            m_led   <= 8'h00;
            m_busy  <= 1'b0;
            m_presc <= 0;
            m_pwm   <= 0;
        end else begin
            tick = (m_presc == CLK_DIV - 1);
            diff = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tgt   = m_pq[i] ? 255 : 0;
                nl[i] = m_level[i];
                if (tgt != m_level[i]) diff = 1'b1;
                if (tick && enable) begin
                    if (tgt > m_level[i])
                        nl[i] = (m_level[i] + FADE_STEP > 255) ? 255 : m_level[i] + FADE_STEP;
                    else if (tgt < m_level[i])
                        nl[i] = (m_level[i] - FADE_STEP < 0) ? 0 : m_level[i] - FADE_STEP;
                end
                nled[i] = enable ? ((m_level[i] == 255) || (m_pwm < m_level[i])) : m_pq[i];
            end
            for (int i = 0; i < 8; i++) m_level[i] <= nl[i];
            m_led   <= nled;
            m_busy  <= enable && diff;
            m_pq    <= pattern_in;
            m_presc <= (m_presc + 1) % CLK_DIV;
            m_pwm   <= (m_pwm + 1) % 256;
        end
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("led_out", {1'b0, led_out}, {1'b0, m_led});
            chk("busy", {8'h00, busy}, {8'h00, m_busy});
        end
    endtask

    task automatic duty(input int bitn, output int cnt);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            chk("led_out", {1'b0, led_out}, {1'b0, m_led});
            if (led_out[bitn]) cnt++;
        end
    endtask

    initial begin : stim
        int cnt;
        reset      = 1'b1;
        enable     = 1'b0;
        pattern_in = 8'h00;

        run(3);
        chk("reset_led", {1'b0, led_out}, 9'h000);
        chk("reset_busy", {8'h00, busy}, 9'h000);
        reset = 1'b0;

        // Fade up bit 0 to full, then a full PWM period must be lit
        enable     = 1'b1;
        pattern_in = 8'h01;
        run(3);
        chk("fade_up_busy", {8'h00, busy}, 9'h001);
        run(27);
        chk("full_busy", {8'h00, busy}, 9'h000);
        duty(0, cnt);
        chk("duty_255", 9'(cnt), 9'd256);

        // Fade down to 0, then a full PWM period must be dark
        pattern_in = 8'h00;
        run(30);
        duty(0, cnt);
        chk("duty_0", 9'(cnt), 9'd0);

        // Reversal mid-fade
        pattern_in = 8'h01;
        run(9);
        pattern_in = 8'h00;
        run(24);

        // Bypass mode
        enable     = 1'b0;
        pattern_in = 8'hA5;
        run(2);
        chk("bypass_led", {1'b0, led_out}, 9'h0A5);
        chk("bypass_busy", {8'h00, busy}, 9'h000);
        run(10);
        enable = 1'b1;
        run(30);
        pattern_in = 8'h18;
        run(6);
        enable = 1'b0;
        run(8);
        enable = 1'b1;
        run(30);

        // Randomized pattern/enable traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) pattern_in = 8'($urandom);
            if ($urandom_range(0, 31) == 0) enable = ~enable;
            run(1);
        end

        // Asynchronous reset between edges in the middle of a fade
        enable     = 1'b1;
        pattern_in = 8'hFF;
        run(11);
        #2 reset = 1'b1;
        #1;
        chk("async_led", {1'b0, led_out}, 9'h000);
        chk("async_busy", {8'h00, busy}, 9'h000);
        run(2);
        #2 reset = 1'b0;
        run(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
